aes_key_expand_seq: RTL and testbench

- Sequential, multi-mode AES key-schedule engine; successor to the single-round combinational round-key generator.
- Supports AES-128, AES-192 and AES-256, selected per job at run time.
- Expands the cipher key one 32-bit word per clock into an internal schedule buffer. The datapath then reads any round key from a registered read port.
- Sits between the key-load interface and the AES round pipeline in the GCM core.

---
 rtl/aes_key_expand_seq_if.sv | 26 ++
 rtl/aes_key_expand_seq.sv | 160 ++++++++++++++++
 tb/tb_aes_key_expand_seq.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/aes_key_expand_seq_if.sv
// rtl/aes_key_expand_seq_if.sv - key-load and round-key read bus for the key schedule engine
interface aes_key_expand_seq_if #(
    parameter int MAX_KEY_BITS = 256
);
    logic                    i_start;
    logic [1:0]              i_key_mode;
    logic [MAX_KEY_BITS-1:0] i_key;
    logic                    i_rd_en;
    logic [3:0]              i_rd_round;
    logic                    o_busy;
    logic                    o_done;
    logic                    o_key_valid;
    logic                    o_mode_err;
    logic [127:0]            o_rd_key;
    logic                    o_rd_err;

    modport master (
        output i_start, i_key_mode, i_key, i_rd_en, i_rd_round,
        input  o_busy, o_done, o_key_valid, o_mode_err, o_rd_key, o_rd_err
    );

    modport slave (
        input  i_start, i_key_mode, i_key, i_rd_en, i_rd_round,
        output o_busy, o_done, o_key_valid, o_mode_err, o_rd_key, o_rd_err
    );
endinterface

// File: rtl/aes_key_expand_seq.sv
// rtl/aes_key_expand_seq.sv - sequential AES-128/192/256 key expansion with registered round-key read port
module aes_sbox (
    input  logic [7:0] plain,
    output logic [7:0] subst
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128), then the affine map.
    always_comb begin
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = plain;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        subst = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module aes_key_expand_seq #(
    parameter int MAX_KEY_BITS = 256,
    parameter int MAX_WORDS    = 60
) (
    input logic                  i_clk,
    input logic                  i_rst,
    aes_key_expand_seq_if.slave  bus
);
    typedef enum logic {IDLE, EXPAND} state_t;

    state_t      state;
    logic [31:0] w [MAX_WORDS];
    logic [1:0]  mode_q;
    logic [5:0]  idx;
    logic [2:0]  modc;
    logic [7:0]  rcon;

    function automatic logic [3:0] mode_nk(input logic [1:0] m);
        return 4'd4 + {1'b0, m, 1'b0};
    endfunction

    logic [3:0] nk, nr, start_nk;
    logic [5:0] total;
    logic       start_legal, load;

    always_comb begin
        nk          = mode_nk(mode_q);
        nr          = nk + 4'd6;
        total       = {nr + 4'd1, 2'b00};
        start_nk    = mode_nk(bus.i_key_mode);
        start_legal = (bus.i_key_mode != 2'b11) &&
                      (128 + 64 * int'(bus.i_key_mode) <= MAX_KEY_BITS);
        load        = (state == IDLE) && bus.i_start && start_legal && !i_rst;
    end

    // Next schedule word: temp selection depends on the position within the Nk-word period.
    logic [31:0] prev, back, sub_in, sub_out, temp, w_new;
    logic        mod_zero, mod_four;

    always_comb begin
        prev     = w[idx - 6'd1];
        back     = w[idx - {2'b00, nk}];
        mod_zero = (modc == 3'd0);
        mod_four = (nk == 4'd8) && (modc == 3'd4);
        sub_in   = mod_zero ? {prev[23:0], prev[31:24]} : prev;
        if (mod_zero)      temp = sub_out ^ {rcon, 24'h0};
        else if (mod_four) temp = sub_out;
        else               temp = prev;
        w_new    = back ^ temp;
    end

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (.plain(sub_in[8*b +: 8]), .subst(sub_out[8*b +: 8]));
    end

    logic [5:0]   rd_base;
    logic [127:0] rd_data;
    logic         rd_ok;

    always_comb begin
        rd_base = {bus.i_rd_round, 2'b00};
        rd_data = {w[rd_base], w[rd_base + 6'd1], w[rd_base + 6'd2], w[rd_base + 6'd3]};
        rd_ok   = bus.o_key_valid && (bus.i_rd_round <= nr);
    end

    // Buffer contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge i_clk) begin
        if (load) begin
            for (int j = 0; j < MAX_KEY_BITS / 32; j++) begin
                if (j < int'(start_nk)) w[j] <= bus.i_key[MAX_KEY_BITS-1-32*j -: 32];
            end
        end else if (state == EXPAND && !i_rst) begin
            w[idx] <= w_new;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state           <= IDLE;
            mode_q          <= 2'b00;
            idx             <= 6'd0;
            modc            <= 3'd0;
            rcon            <= 8'h01;
            bus.o_busy      <= 1'b0;
            bus.o_done      <= 1'b0;
            bus.o_key_valid <= 1'b0;
            bus.o_mode_err  <= 1'b0;
            bus.o_rd_key    <= '0;
            bus.o_rd_err    <= 1'b0;
        end else begin
            bus.o_done     <= 1'b0;
            bus.o_mode_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        if (start_legal) begin
                            mode_q          <= bus.i_key_mode;
                            idx             <= {2'b00, start_nk};
                            modc            <= 3'd0;
                            rcon            <= 8'h01;
                            bus.o_key_valid <= 1'b0;
                            bus.o_busy      <= 1'b1;
                            state           <= EXPAND;
                        end else begin
                            bus.o_mode_err  <= 1'b1;
                        end
                    end
                end
                EXPAND: begin
                    idx  <= idx + 6'd1;
                    modc <= ({1'b0, modc} == nk - 4'd1) ? 3'd0 : modc + 3'd1;
                    if (mod_zero) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                    if (idx == total - 6'd1) begin
                        state           <= IDLE;
                        bus.o_busy      <= 1'b0;
                        bus.o_done      <= 1'b1;
                        bus.o_key_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (bus.i_rd_en) begin
                bus.o_rd_key <= rd_ok ? rd_data : '0;
                bus.o_rd_err <= !rd_ok;
            end
        end
    end
endmodule

// File: tb/tb_aes_key_expand_seq.sv
// tb/tb_aes_key_expand_seq.sv - randomized self-checking bench against a FIPS-197 style key schedule model
module tb_aes_key_expand_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes_key_expand_seq_if #(.MAX_KEY_BITS(256)) bus ();

    aes_key_expand_seq #(.MAX_KEY_BITS(256), .MAX_WORDS(60)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [7:0]  sb [256];
    logic [31:0] mw [60];

    // S-box table built by walking the multiplicative group with generator 3.
    task automatic build_sbox();
        logic [7:0] p, q;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'b0000};
            if (q[7]) q = q ^ 8'h09;
            sb[p] = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]} ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
    endfunction

    function automatic logic [7:0] rcon_of(input int n);
        logic [7:0] rc;
        rc = 8'h01;
        for (int k = 1; k < n; k++) rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
        return rc;
    endfunction

    task automatic model_expand(input int mode, input logic [255:0] key);
        int nk, nr;
        logic [31:0] t;
        nk = 4 + 2 * mode;
        nr = nk + 6;
        for (int i = 0; i < nk; i++) mw[i] = key[255 - 32 * i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = mw[i - 1];
            if (i % nk == 0)                 t = sub_word({t[23:0], t[31:24]}) ^ {rcon_of(i / nk), 24'h0};
            else if (nk == 8 && i % nk == 4) t = sub_word(t);
            mw[i] = mw[i - nk] ^ t;
        end
    endtask

    function automatic logic [127:0] model_round(input int r);
        return {mw[4 * r], mw[4 * r + 1], mw[4 * r + 2], mw[4 * r + 3]};
    endfunction

    task automatic read_check(input int r, input logic [127:0] exp_key, input logic exp_err, input string tag);
        @(negedge clk);
        bus.i_rd_en    = 1'b1;
        bus.i_rd_round = r[3:0];
        @(negedge clk);
        bus.i_rd_en    = 1'b0;
        check_eq({tag, "_key"}, bus.o_rd_key, exp_key);
        check_eq({tag, "_err"}, bus.o_rd_err, exp_err);
    endtask

    task automatic run_job(input int mode, input logic [255:0] key, input string tag);
        int edges, nk;
        nk = 4 + 2 * mode;
        @(negedge clk);
        bus.i_start    = 1'b1;
        bus.i_key_mode = mode[1:0];
        bus.i_key      = key;
        @(negedge clk);
        bus.i_start = 1'b0;
        edges = 1;
        check_eq({tag, "_busy"}, bus.o_busy, 1);
        while (!bus.o_done && edges < 200) begin
            @(negedge clk);
            edges++;
        end
        check_eq({tag, "_latency"}, edges, 4 * (nk + 7) - nk + 1);
        check_eq({tag, "_valid"}, bus.o_key_valid, 1);
        check_eq({tag, "_busy_end"}, bus.o_busy, 0);
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, bus.o_done, 0);
        model_expand(mode, key);
    endtask

    task automatic check_all_rounds(input int mode, input string tag);
        int nr;
        nr = 10 + 2 * mode;
        for (int r = 0; r <= nr + 1 && r < 16; r++)
            read_check(r, (r <= nr) ? model_round(r) : 128'h0, r > nr, $sformatf("%s_r%0d", tag, r));
    endtask

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    initial begin
        int edges, saw_done, mode;
        logic [255:0] key;
        bus.i_start    = 1'b0;
        bus.i_key_mode = 2'b00;
        bus.i_key      = '0;
        bus.i_rd_en    = 1'b0;
        bus.i_rd_round = 4'd0;
        build_sbox();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("rst_busy", bus.o_busy, 0);
        check_eq("rst_done", bus.o_done, 0);
        check_eq("rst_valid", bus.o_key_valid, 0);
        check_eq("rst_mode_err", bus.o_mode_err, 0);
        check_eq("rst_rd_key", bus.o_rd_key, 0);
        check_eq("rst_rd_err", bus.o_rd_err, 0);
        read_check(0, 128'h0, 1'b1, "rd_not_valid");

        run_job(0, K128, "k128");
        read_check(1, 128'ha0fafe1788542cb123a339392a6c7605, 1'b0, "k128_r1_vec");
        read_check(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0, "k128_r10_vec");
        read_check(11, 128'h0, 1'b1, "k128_r11_vec");
        check_all_rounds(0, "k128");

        run_job(1, K192, "k192");
        read_check(12, 128'he98ba06f448c773c8ecc720401002202, 1'b0, "k192_r12_vec");
        check_all_rounds(1, "k192");

        run_job(2, K256, "k256");
        read_check(14, 128'hfe4890d1e6188d0b046df344706c631e, 1'b0, "k256_r14_vec");
        read_check(0, 128'h603deb1015ca71be2b73aef0857d7781, 1'b0, "k256_r0_vec");
        check_all_rounds(2, "k256");

        @(negedge clk);
        bus.i_start    = 1'b1;
        bus.i_key_mode = 2'b11;
        bus.i_key      = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        bus.i_start = 1'b0;
        check_eq("mode11_err", bus.o_mode_err, 1);
        check_eq("mode11_busy", bus.o_busy, 0);
        @(negedge clk);
        check_eq("mode11_err_pulse", bus.o_mode_err, 0);
        check_eq("mode11_busy2", bus.o_busy, 0);
        check_eq("mode11_valid", bus.o_key_valid, 1);
        read_check(14, 128'hfe4890d1e6188d0b046df344706c631e, 1'b0, "mode11_keep");

        @(negedge clk);
        bus.i_start    = 1'b1;
        bus.i_key_mode = 2'b00;
        bus.i_key      = K128;
        @(negedge clk);
        bus.i_start = 1'b0;
        edges = 1;
        while (edges < 10) begin @(negedge clk); edges++; end
        bus.i_start    = 1'b1;
        bus.i_key_mode = 2'b10;
        bus.i_key      = K256;
        bus.i_rd_en    = 1'b1;
        bus.i_rd_round = 4'd3;
        @(negedge clk);
        edges++;
        bus.i_start = 1'b0;
        bus.i_rd_en = 1'b0;
        check_eq("exp_rd_err", bus.o_rd_err, 1);
        check_eq("exp_rd_key", bus.o_rd_key, 0);
        check_eq("exp_no_mode_err", bus.o_mode_err, 0);
        while (!bus.o_done && edges < 200) begin @(negedge clk); edges++; end
        check_eq("restart_latency", edges, 41);
        model_expand(0, K128);
        read_check(10, model_round(10), 1'b0, "restart_r10");
        read_check(11, 128'h0, 1'b1, "restart_r11");

        @(negedge clk);
        bus.i_start    = 1'b1;
        bus.i_key_mode = 2'b10;
        bus.i_key      = K256;
        @(negedge clk);
        bus.i_start = 1'b0;
        edges = 1;
        while (edges < 20) begin @(negedge clk); edges++; end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_busy", bus.o_busy, 0);
        check_eq("midrst_valid", bus.o_key_valid, 0);
        check_eq("midrst_done", bus.o_done, 0);
        check_eq("midrst_rd_key", bus.o_rd_key, 0);
        saw_done = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus.o_done) saw_done = 1;
        end
        check_eq("midrst_no_done", saw_done, 0);
        run_job(0, K128, "post_rst");
        read_check(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0, "post_rst_r10");

        for (int t = 0; t < 6; t++) begin
            mode = $urandom_range(0, 2);
            key  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if (mode == 0) key[127:0] = '0;
            if (mode == 1) key[63:0]  = '0;
            run_job(mode, key, $sformatf("rnd%0d", t));
            check_all_rounds(mode, $sformatf("rnd%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
